// File: rtl/window_stream_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : window_stream_gen_if
// Description : Pixel-in / window-out bundle for window_stream_gen.
//               master = pixel source (drives pixels, observes windows)
//               slave  = window generator
//               out_x/out_y exist only when WINDOW_STREAM_COORD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface window_stream_gen_if #(
    parameter int PIXEL_W     = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int ROW_WIDTH   = 100,
    parameter int NUM_ROWS    = 100
);
    localparam int c_xw = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
    localparam int c_yw = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    logic [PIXEL_W-1:0]                                  pixel_in;
    logic                                                in_valid;
    logic                                                in_sof;
    logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PIXEL_W-1:0] window;
    logic                                                window_valid;
    logic                                                frame_done;
`ifdef WINDOW_STREAM_COORD_EN
    logic [c_xw-1:0]                                     out_x;
    logic [c_yw-1:0]                                     out_y;
`endif

    modport master (
        output pixel_in, in_valid, in_sof,
        input  window, window_valid, frame_done
`ifdef WINDOW_STREAM_COORD_EN
        , input out_x, out_y
`endif
    );

    modport slave (
        input  pixel_in, in_valid, in_sof,
        output window, window_valid, frame_done
`ifdef WINDOW_STREAM_COORD_EN
        , output out_x, out_y
`endif
    );
endinterface
`default_nettype wire

// File: rtl/window_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : window_stream_gen
// Description : Streaming KERNEL_SIZE x KERNEL_SIZE sliding-window generator.
//               Raster-order pixels in, K-1 cascaded line buffers, registered
//               window with valid strobe and end-of-frame pulse. in_sof
//               resynchronises to (0,0) at any time.
//               Optional macro WINDOW_STREAM_COORD_EN adds out_x/out_y.
// Revision    : 1.0 - initial release
// ============================================================================
module window_stream_gen #(
    parameter int PIXEL_W     = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int ROW_WIDTH   = 100,
    parameter int NUM_ROWS    = 100
) (
    input  wire logic          clk,
    input  wire logic          reset,
    window_stream_gen_if.slave bus
);
    localparam int c_xw = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
    localparam int c_yw = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int c_k  = KERNEL_SIZE;
    localparam int c_lb = KERNEL_SIZE - 1;

    localparam logic [c_xw-1:0] c_col_last = c_xw'(ROW_WIDTH - 1);
    localparam logic [c_xw-1:0] c_col_k    = c_xw'(KERNEL_SIZE - 1);
    localparam logic [c_xw-1:0] c_col_one  = c_xw'(1);
    localparam logic [c_yw-1:0] c_row_last = c_yw'(NUM_ROWS - 1);
    localparam logic [c_yw-1:0] c_row_k    = c_yw'(KERNEL_SIZE - 1);
    localparam logic [c_yw-1:0] c_row_one  = c_yw'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t                                  r_state;
    logic [c_xw-1:0]                         r_col;
    logic [c_yw-1:0]                         r_row;
    logic [c_k-1:0][c_k-1:0][PIXEL_W-1:0]    r_window;
    logic                                    r_window_valid;
    logic                                    r_frame_done;
    // Line-buffer data is never reset; window_valid gating hides stale rows.
    logic [PIXEL_W-1:0]                      r_lbuf [c_lb][ROW_WIDTH];

    logic [c_xw-1:0] w_col_cur;
    logic [c_xw-1:0] w_col_nxt;
    logic [c_yw-1:0] w_row_cur;
    logic [c_yw-1:0] w_row_nxt;
    logic            w_col_end;
    logic            w_frame_end;
    logic            w_streaming;

    // Position of the current beat (in_sof forces it to (0,0)) and the next one.
    always_comb begin
        w_col_cur   = bus.in_sof ? '0 : r_col;
        w_row_cur   = bus.in_sof ? '0 : r_row;
        w_streaming = !bus.in_sof && (r_state == ST_STREAM);
        w_col_end   = (w_col_cur == c_col_last);
        w_frame_end = w_col_end && (w_row_cur == c_row_last);
        w_col_nxt   = w_col_end ? '0 : (w_col_cur + c_col_one);
        if (!w_col_end) begin
            w_row_nxt = w_row_cur;
        end else if (w_row_cur == c_row_last) begin
            w_row_nxt = '0;
        end else begin
            w_row_nxt = w_row_cur + c_row_one;
        end
    end

    // Frame FSM, counters and registered window outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_col          <= '0;
            r_row          <= '0;
            r_window       <= '0;
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
            if (bus.in_valid) begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
                for (int r = 0; r < c_k; r++) begin
                    for (int c = 0; c < c_k - 1; c++) begin
                        r_window[r][c] <= r_window[r][c+1];
                    end
                end
                for (int r = 0; r < c_lb; r++) begin
                    r_window[r][c_k-1] <= r_lbuf[r][w_col_cur];
                end
                r_window[c_k-1][c_k-1] <= bus.pixel_in;
                // STREAM means the beat's row is >= K-1; also check column.
                r_window_valid <= w_streaming && (w_col_cur >= c_col_k);
                r_frame_done   <= w_frame_end;
                r_state        <= (w_row_nxt >= c_row_k) ? ST_STREAM : ST_FILL;
            end
        end
    end

    // Cascaded line buffers: each row moves up one buffer, new pixel enters the last.
    always_ff @(posedge clk) begin
        if (!reset && bus.in_valid) begin
            for (int r = 0; r < c_lb - 1; r++) begin
                r_lbuf[r][w_col_cur] <= r_lbuf[r+1][w_col_cur];
            end
            r_lbuf[c_lb-1][w_col_cur] <= bus.pixel_in;
        end
    end

    assign bus.window       = r_window;
    assign bus.window_valid = r_window_valid;
    assign bus.frame_done   = r_frame_done;

`ifdef WINDOW_STREAM_COORD_EN
    logic [c_xw-1:0] r_out_x;
    logic [c_yw-1:0] r_out_y;

    // Coordinates of the newest pixel, registered alongside the window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_x <= '0;
            r_out_y <= '0;
        end else if (bus.in_valid) begin
            r_out_x <= w_col_cur;
            r_out_y <= w_row_cur;
        end
    end

    assign bus.out_x = r_out_x;
    assign bus.out_y = r_out_y;
`endif
endmodule
`default_nettype wire

// File: tb/tb_window_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_stream_gen
// Description : Self-checking bench for window_stream_gen (K=3, 4x4 frames).
//               Table-driven frames, hand-written resync/reset sequences and
//               random traffic checked against an image-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_stream_gen;
    localparam int PW = 8;
    localparam int K  = 3;
    localparam int RW = 4;
    localparam int NR = 4;
    localparam int WB = K * K * PW;

    logic clk;
    logic reset;

    window_stream_gen_if #(.PIXEL_W(PW), .KERNEL_SIZE(K), .ROW_WIDTH(RW), .NUM_ROWS(NR)) bus_i ();

    window_stream_gen #(.PIXEL_W(PW), .KERNEL_SIZE(K), .ROW_WIDTH(RW), .NUM_ROWS(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_done = 0;

    // Reference model: frame image indexed by (row, col) plus a linear pixel index.
    logic [PW-1:0] img [NR][RW];
    int            m_p;
    logic          m_valid;
    logic          m_done;
    logic          m_chk_win;
    logic [WB-1:0] m_win;
    int            m_x;
    int            m_y;

    typedef struct {
        bit            v;
        logic [PW-1:0] pix;
        bit            exp_valid;
        bit            exp_done;
        logic [WB-1:0] exp_win;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Window whose top-left pixel value is tl, for frames valued row*RW+col+1.
    function automatic logic [WB-1:0] mkwin(input int tl);
        logic [WB-1:0] w;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                w[(i*K+j)*PW +: PW] = PW'(tl + i*RW + j);
        return w;
    endfunction

    // One clock: drive inputs, update model at the edge, compare at negedge.
    task automatic cycle(input bit rst, input bit v, input bit s, input logic [PW-1:0] pix);
        int r;
        int c;
        reset          = rst;
        bus_i.in_valid = v;
        bus_i.in_sof   = s;
        bus_i.pixel_in = pix;
        @(posedge clk);
        if (rst) begin
            m_p = 0; m_valid = 0; m_done = 0; m_chk_win = 1; m_win = '0;
            m_x = 0; m_y = 0;
        end else if (v) begin
            if (s) m_p = 0;
            r = m_p / RW;
            c = m_p % RW;
            img[r][c] = pix;
            m_valid   = (r >= K-1) && (c >= K-1);
            m_done    = (m_p == RW*NR - 1);
            m_chk_win = m_valid;
            if (m_valid)
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        m_win[(i*K+j)*PW +: PW] = img[r-K+1+i][c-K+1+j];
            m_x = c;
            m_y = r;
            m_p = (m_p + 1) % (RW*NR);
        end else begin
            m_valid = 0; m_done = 0; m_chk_win = 0;
        end
        @(negedge clk);
        if (bus_i.frame_done === 1'b1) n_done++;
        chk("model_valid", WB'(bus_i.window_valid), WB'(m_valid));
        chk("model_done", WB'(bus_i.frame_done), WB'(m_done));
        if (m_chk_win) chk("model_window", bus_i.window, m_win);
`ifdef WINDOW_STREAM_COORD_EN
        chk("model_out_x", WB'(bus_i.out_x), WB'(m_x));
        chk("model_out_y", WB'(bus_i.out_y), WB'(m_y));
`endif
    endtask

    // A full 4x4 frame valued 1..16, optionally with in_sof on the first pixel.
    task automatic run_frame(input string name, input bit sof_first);
        n_done = 0;
        for (int p = 1; p <= RW*NR; p++) begin
            cycle(0, 1, sof_first && (p == 1), PW'(p));
            if (p == 11) chk({name, "_first_win"}, bus_i.window, mkwin(1));
            if (p == 16) chk({name, "_last_win"}, bus_i.window, mkwin(6));
        end
        chk({name, "_done_cnt"}, WB'(n_done), WB'(1));
    endtask

    initial begin
        vec_t e;
        logic [WB-1:0] first_win;
        reset = 1'b1;
        bus_i.in_valid = 1'b0;
        bus_i.in_sof = 1'b0;
        bus_i.pixel_in = '0;
        first_win = {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1};

        // Frame A: continuous; frame B: back-to-back, in_valid toggling 1,0.
        for (int p = 1; p <= RW*NR; p++) begin
            e.v = 1; e.pix = PW'(p);
            e.exp_valid = ((p-1)/RW >= K-1) && ((p-1)%RW >= K-1);
            e.exp_done = (p == RW*NR);
            e.exp_win = e.exp_valid ? mkwin(p - 10) : '0;
            tbl.push_back(e);
        end
        for (int p = 1; p <= RW*NR; p++) begin
            e.v = 1; e.pix = PW'(p);
            e.exp_valid = ((p-1)/RW >= K-1) && ((p-1)%RW >= K-1);
            e.exp_done = (p == RW*NR);
            e.exp_win = e.exp_valid ? mkwin(p - 10) : '0;
            tbl.push_back(e);
            e.v = 0; e.pix = 8'hEE; e.exp_valid = 0; e.exp_done = 0; e.exp_win = '0;
            tbl.push_back(e);
        end

        // Reset state.
        cycle(1, 0, 0, '0);
        chk("reset_window", bus_i.window, '0);
        chk("reset_valid", WB'(bus_i.window_valid), '0);
        chk("reset_done", WB'(bus_i.frame_done), '0);
        cycle(0, 0, 0, '0);

        foreach (tbl[i]) begin
            cycle(0, tbl[i].v, 0, tbl[i].pix);
            chk("tbl_valid", WB'(bus_i.window_valid), WB'(tbl[i].exp_valid));
            chk("tbl_done", WB'(bus_i.frame_done), WB'(tbl[i].exp_done));
            if (tbl[i].exp_valid) chk("tbl_window", bus_i.window, tbl[i].exp_win);
            if (i == 10) chk("tbl_first_win_literal", bus_i.window, first_win);
        end

        // Resync mid-frame: 6 pixels, then in_sof restarts a full frame.
        n_done = 0;
        for (int p = 1; p <= 6; p++) cycle(0, 1, 0, PW'(p));
        chk("abort_no_done", WB'(n_done), '0);
        run_frame("sof_restart", 1);

        // Reset after pixel 11 with in_valid/in_sof high.
        for (int p = 1; p <= 11; p++) cycle(0, 1, 0, PW'(p));
        chk("pre_reset_valid", WB'(bus_i.window_valid), WB'(1));
        cycle(1, 1, 1, 8'hAA);
        chk("midreset_window", bus_i.window, '0);
        chk("midreset_valid", WB'(bus_i.window_valid), '0);
        run_frame("after_reset", 0);

        // in_sof on the first pixel right after a natural wrap.
        run_frame("sof_at_wrap", 1);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            bit rr;
            bit vv;
            rr = ($urandom_range(0, 99) == 0);
            vv = ($urandom_range(0, 9) < 7);
            cycle(rr, vv, vv && ($urandom_range(0, 39) == 0), PW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
